// File: rtl/toysram_access_arbiter.sv
// toysram_access_arbiter: shares the single-port toy SRAM between the Wishbone slave and the LA test port
// Ports: wb_clk_i/wb_rst_i clock and async reset; wbs_* Wishbone slave (ack + read data);
// la_* test port (edge-triggered request, done pulse, last read data); sram_* array enable/write/mask/address/data.
module toysram_access_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  localparam int NB = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [NB-1:0]     wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [DATA_W-1:0] la_dat_i,
  output logic              la_ack_o,
  output logic [DATA_W-1:0] la_dat_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [NB-1:0]     sram_wmask_o,
  output logic [ADDR_W-1:0] sram_adr_o,
  output logic [DATA_W-1:0] sram_dat_o,
  input  logic [DATA_W-1:0] sram_dat_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic we_q, we_d;
  logic en_q, en_d;
  logic [NB-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
  logic [DATA_W-1:0] la_dat_q, la_dat_d;
  logic wb_ack_q, wb_ack_d;
  logic la_ack_q, la_ack_d;
  logic la_prev_q, la_pend_q, la_pend_d;
  logic abort_q, abort_d;
  logic [2:0] cnt_q, cnt_d;
  logic idle, wb_req, gnt_wb, gnt_la, gnt, wait_done, to_ack, capture;
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};
  assign wbs_ack_o = wb_ack_q;
  assign wbs_dat_o = wb_dat_q;
  assign la_ack_o = la_ack_q;
  assign la_dat_o = la_dat_q;
  assign sram_en_o = en_q;
  assign sram_we_o = en_q & we_q;
  assign sram_wmask_o = (en_q & we_q) ? mask_q : '0;
  assign sram_adr_o = adr_q;
  assign sram_dat_o = dat_q;
  always_comb begin
    idle = state_q == IDLE;
    wb_req = wbs_cyc_i & wbs_stb_i;
    // owner_q is the last grant (1 = LA), so it also drives the round-robin tie-break
    gnt_wb = idle & wb_req & (~la_pend_q | owner_q);
    gnt_la = idle & la_pend_q & (~wb_req | ~owner_q);
    gnt = gnt_wb | gnt_la;
    wait_done = cnt_q == 3'(RD_LAT - 1);
    capture = state_q == WAIT & wait_done;
    to_ack = (state_q == ISSUE & we_q) | capture;
    abort_d = gnt ? 1'b0 : abort_q | (~idle & ~owner_q & ~wbs_cyc_i);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gnt ? ISSUE : IDLE;
      ISSUE:   state_d = we_q ? ACK : WAIT;
      WAIT:    state_d = wait_done ? ACK : WAIT;
      default: state_d = IDLE;
    endcase
    cnt_d = state_q == WAIT ? cnt_q + 3'd1 : 3'd0;
    owner_d = gnt ? gnt_la : owner_q;
    we_d = gnt ? (gnt_la ? la_we_i : wbs_we_i) : we_q;
    mask_d = gnt ? (gnt_la ? {NB{1'b1}} : wbs_sel_i) : mask_q;
    adr_d = gnt ? (gnt_la ? la_adr_i : wbs_adr_i[ADDR_W+1:2]) : adr_q;
    dat_d = gnt ? (gnt_la ? la_dat_i : wbs_dat_i) : dat_q;
    en_d = gnt;
    wb_ack_d = to_ack & ~owner_q & ~abort_d;
    la_ack_d = to_ack & owner_q;
    wb_dat_d = capture & ~owner_q ? sram_dat_i : wb_dat_q;
    la_dat_d = capture & owner_q ? sram_dat_i : la_dat_q;
    // an edge arriving while a request is already pending is absorbed
    la_pend_d = gnt_la ? 1'b0 : la_pend_q | (la_req_i & ~la_prev_q);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      we_q <= 1'b0;
      en_q <= 1'b0;
      mask_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      wb_dat_q <= '0;
      la_dat_q <= '0;
      wb_ack_q <= 1'b0;
      la_ack_q <= 1'b0;
      la_prev_q <= 1'b0;
      la_pend_q <= 1'b0;
      abort_q <= 1'b0;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      en_q <= en_d;
      mask_q <= mask_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      wb_dat_q <= wb_dat_d;
      la_dat_q <= la_dat_d;
      wb_ack_q <= wb_ack_d;
      la_ack_q <= la_ack_d;
      la_prev_q <= la_req_i;
      la_pend_q <= la_pend_d;
      abort_q <= abort_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
